// File: rtl/plic_lite.sv
// plic_lite: platform-level interrupt arbiter in front of the core's interrupt input.
//   Per-source edge gateways latch requests into pending. The highest-priority enabled
//   source above threshold is presented to the core. A claim/complete handshake runs
//   through a small register port.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   src_i           raw sources (src_i[k] is ID k+1), already synchronous to clk
//   we_i/re_i       register write/read strobes (mutually exclusive)
//   addr_i/wdata_i  byte address and write data
//   rdata_o         registered read data, valid the cycle after re_i
//   int_req_o       request to core; low while a claim is outstanding
//   int_id_o        registered ID of the current winner, 0 when none
// Register map: 0x00 ENABLE, 0x04 THRESHOLD, 0x08 CLAIM (rd=claim, wr=complete),
//   0x10+4*k PRIO[k]. Unmapped reads return 0 and unmapped writes are dropped.
module plic_lite #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [7:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               int_req_o,
    output logic [ID_W-1:0]    int_id_o
);
    typedef enum logic [1:0] {IDLE, NOTIFY, CLAIMED} state_t;

    localparam logic [7:0] A_EN = 8'h00, A_TH = 8'h04, A_CLAIM = 8'h08;

    logic [NUM_SRC-1:0]             enable_q, enable_d;
    logic [PRIO_W-1:0]              thresh_q, thresh_d;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [NUM_SRC-1:0]             pending_q, pending_d;
    logic [NUM_SRC-1:0]             insvc_q, insvc_d;
    logic [NUM_SRC-1:0]             src_prev_q;
    logic [ID_W-1:0]                claimed_q, claimed_d;
    state_t                         state_q, state_d;
    logic [31:0]                    rdata_q, rdata_d;
    logic                           int_req_q;
    logic [ID_W-1:0]                int_id_q;

    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_p;
    logic               any_cand;
    logic               claim_go, cmpl_wr, cmpl_claimed;
    logic [NUM_SRC-1:0] claim_mask, cmpl_mask, edge_v;

    // Winner: strict '>' while scanning upward keeps the lowest index on ties.
    // Candidates have PRIO > THRESHOLD >= 0, so win_p starting at 0 never hides one.
    always_comb begin
        win_id   = '0;
        win_p    = '0;
        any_cand = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (pending_q[k] && enable_q[k] && (prio_q[k] > thresh_q) && (prio_q[k] > win_p)) begin
                win_p    = prio_q[k];
                win_id   = ID_W'(k + 1);
                any_cand = 1'b1;
            end
        end
    end

    // Claim acts on the registered winner, the same value software reads back.
    assign claim_go = re_i && (addr_i == A_CLAIM) && (int_id_q != '0);
    assign cmpl_wr  = we_i && (addr_i == A_CLAIM);
    assign edge_v   = src_i & ~src_prev_q;

    always_comb begin
        claim_mask = '0;
        cmpl_mask  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            claim_mask[k] = claim_go && (int_id_q == ID_W'(k + 1));
            cmpl_mask[k]  = cmpl_wr && (wdata_i == 32'(k + 1)) && insvc_q[k];
        end
    end

    assign cmpl_claimed = (state_q == CLAIMED) && (|cmpl_mask) && (wdata_i == 32'(claimed_q));

    // Edges are accepted only against the pre-cycle pending/in-service bits, so an edge
    // landing in the claim or complete cycle of its own source is dropped.
    assign pending_d = (pending_q & ~claim_mask) | (edge_v & ~pending_q & ~insvc_q);
    assign insvc_d   = (insvc_q | claim_mask) & ~cmpl_mask;

    always_comb begin
        state_d   = state_q;
        claimed_d = claim_go ? int_id_q : claimed_q;
        case (state_q)
            IDLE:    if (claim_go) state_d = CLAIMED; else if (any_cand) state_d = NOTIFY;
            NOTIFY:  if (claim_go) state_d = CLAIMED; else if (!any_cand) state_d = IDLE;
            CLAIMED: if (cmpl_claimed) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enable_d = enable_q;
        thresh_d = thresh_q;
        prio_d   = prio_q;
        rdata_d  = '0;
        if (we_i && addr_i == A_EN) enable_d = wdata_i[NUM_SRC-1:0];
        if (we_i && addr_i == A_TH) thresh_d = wdata_i[PRIO_W-1:0];
        if (re_i) begin
            if (addr_i == A_EN)    rdata_d[NUM_SRC-1:0] = enable_q;
            if (addr_i == A_TH)    rdata_d[PRIO_W-1:0]  = thresh_q;
            if (addr_i == A_CLAIM) rdata_d[ID_W-1:0]    = int_id_q;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (addr_i == 8'(16 + 4 * k)) begin
                if (we_i) prio_d[k] = wdata_i[PRIO_W-1:0];
                if (re_i) rdata_d[PRIO_W-1:0] = prio_q[k];
            end
        end
    end

    // Tracks the source even through reset so a level held across reset is not an edge.
    always_ff @(posedge clk) src_prev_q <= src_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q  <= '0;
            thresh_q  <= '0;
            prio_q    <= '0;
            pending_q <= '0;
            insvc_q   <= '0;
            claimed_q <= '0;
            state_q   <= IDLE;
            rdata_q   <= '0;
            int_req_q <= 1'b0;
            int_id_q  <= '0;
        end else begin
            enable_q  <= enable_d;
            thresh_q  <= thresh_d;
            prio_q    <= prio_d;
            pending_q <= pending_d;
            insvc_q   <= insvc_d;
            claimed_q <= claimed_d;
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            int_req_q <= (state_d == NOTIFY);
            int_id_q  <= win_id;
        end
    end

    assign rdata_o   = rdata_q;
    assign int_req_o = int_req_q;
    assign int_id_o  = int_id_q;
endmodule

// File: tb/tb_plic_lite.sv
module tb_plic_lite;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  src_i = '0;
    logic        we_i = 1'b0, re_i = 1'b0;
    logic [7:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        int_req_o;
    logic [3:0]  int_id_o;

    plic_lite #(.NUM_SRC(8), .PRIO_W(3), .ID_W(4)) dut (
        .clk(clk), .rst(rst), .src_i(src_i), .we_i(we_i), .re_i(re_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .int_req_o(int_req_o), .int_id_o(int_id_o)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: interrupt controller state as plain arrays and integers.
    int       m_prio[8];
    bit [7:0] m_en, m_pend, m_insvc, m_prev;
    int       m_th, m_phase, m_claimed, m_id, m_rd; // phase: 0 idle, 1 notify, 2 claimed
    bit       m_req;

    task automatic model_step(bit r, bit w, bit rd, logic [7:0] a, logic [31:0] wd, logic [7:0] s);
        int best, bestp, nphase, rdv;
        bit [7:0] np, ni;
        bit took;
        if (r) begin
            foreach (m_prio[k]) m_prio[k] = 0;
            m_en = 0; m_pend = 0; m_insvc = 0; m_th = 0; m_phase = 0;
            m_claimed = 0; m_id = 0; m_rd = 0; m_req = 0;
        end else begin
            best = 0; bestp = 0;
            for (int k = 0; k < 8; k++)
                if (m_pend[k] && m_en[k] && m_prio[k] > m_th && m_prio[k] > bestp) begin
                    bestp = m_prio[k]; best = k + 1;
                end
            rdv = 0;
            if (rd) begin
                if (a == 8'h00) rdv = int'(m_en);
                else if (a == 8'h04) rdv = m_th;
                else if (a == 8'h08) rdv = m_id;
                else if (a >= 8'h10 && a < 8'h30 && a % 4 == 0) rdv = m_prio[(a - 16) / 4];
            end
            np = m_pend; ni = m_insvc; nphase = m_phase; took = 0;
            if (rd && a == 8'h08 && m_id != 0) begin
                np[m_id-1] = 0; ni[m_id-1] = 1; nphase = 2; m_claimed = m_id; took = 1;
            end
            for (int k = 0; k < 8; k++)
                if (s[k] && !m_prev[k] && !m_pend[k] && !m_insvc[k]) np[k] = 1;
            if (w && a == 8'h08 && wd >= 1 && wd <= 8 && m_insvc[wd-1]) begin
                ni[wd-1] = 0;
                if (m_phase == 2 && int'(wd) == m_claimed) nphase = 0;
            end
            if (!took) begin
                if (m_phase == 0 && best != 0) nphase = 1;
                if (m_phase == 1 && best == 0) nphase = 0;
            end
            if (w) begin
                if (a == 8'h00) m_en = wd[7:0];
                if (a == 8'h04) m_th = int'(wd[2:0]);
                if (a >= 8'h10 && a < 8'h30 && a % 4 == 0) m_prio[(a - 16) / 4] = int'(wd[2:0]);
            end
            m_pend = np; m_insvc = ni; m_phase = nphase;
            m_id = best; m_req = (nphase == 1); m_rd = rdv;
        end
        m_prev = s;
    endtask

    // Drive one cycle; outputs are sampled 1ns after the edge.
    task automatic drive(bit r, bit w, bit rd, logic [7:0] a, logic [31:0] wd, logic [7:0] s);
        rst = r; we_i = w; re_i = rd; addr_i = a; wdata_i = wd; src_i = s;
        @(posedge clk);
        model_step(r, w, rd, a, wd, s);
        #1;
    endtask

    typedef struct {
        bit rst, we, re;
        logic [7:0] addr; logic [31:0] wd; logic [7:0] src;
        bit req; logic [3:0] id; logic [31:0] rd;
    } vec_t;
    vec_t tbl[$];

    function automatic void V(bit r, bit w, bit rd, logic [7:0] a, logic [31:0] wd, logic [7:0] s,
                              bit req, logic [3:0] id, logic [31:0] rdv);
        vec_t v;
        v.rst = r; v.we = w; v.re = rd; v.addr = a; v.wd = wd; v.src = s;
        v.req = req; v.id = id; v.rd = rdv;
        tbl.push_back(v);
    endfunction

    initial begin
        // reset with sources high, then all registers read 0
        V(1,0,0,8'h00,0,8'hFF, 0,0,0);   V(1,0,0,8'h00,0,8'hFF, 0,0,0);
        V(0,0,1,8'h00,0,8'hFF, 0,0,0);   V(0,0,1,8'h04,0,8'hFF, 0,0,0);
        V(0,0,1,8'h08,0,8'hFF, 0,0,0);   V(0,0,1,8'h10,0,8'hFF, 0,0,0);
        V(0,0,1,8'h2C,0,8'h00, 0,0,0);
        // basic single source
        V(0,1,0,8'h18,3,0, 0,0,0);       V(0,1,0,8'h00,4,0, 0,0,0);
        V(0,0,0,0,0,8'h04, 0,0,0);       V(0,0,0,0,0,0, 1,3,0);
        V(0,0,1,8'h08,0,0, 0,3,3);       V(0,0,0,0,0,0, 0,0,0);
        V(0,1,0,8'h08,3,0, 0,0,0);       V(0,0,1,8'h08,0,0, 0,0,0);
        // arbitration: tie on prio 5 goes to lower index
        V(0,1,0,8'h14,2,0, 0,0,0);       V(0,1,0,8'h24,5,0, 0,0,0);
        V(0,1,0,8'h28,5,0, 0,0,0);       V(0,1,0,8'h00,8'hFF,0, 0,0,0);
        V(0,0,0,0,0,8'h62, 0,0,0);       V(0,0,0,0,0,0, 1,6,0);
        V(0,0,1,8'h08,0,0, 0,6,6);       V(0,0,0,0,0,0, 0,7,0);
        V(0,1,0,8'h08,6,0, 0,7,0);       V(0,0,0,0,0,0, 1,7,0);
        V(0,0,1,8'h08,0,0, 0,7,7);       V(0,0,0,0,0,0, 0,2,0);
        V(0,1,0,8'h08,7,0, 0,2,0);       V(0,0,0,0,0,0, 1,2,0);
        V(0,0,1,8'h08,0,0, 0,2,2);       V(0,0,0,0,0,0, 0,0,0);
        V(0,1,0,8'h08,2,0, 0,0,0);       V(0,0,0,0,0,0, 0,0,0);
        // threshold masks equal priority; lowering it releases the request
        V(0,1,0,8'h04,4,0, 0,0,0);       V(0,1,0,8'h10,4,0, 0,0,0);
        V(0,0,0,0,0,8'h01, 0,0,0);       V(0,0,0,0,0,0, 0,0,0);
        V(0,1,0,8'h04,3,0, 0,0,0);       V(0,0,0,0,0,0, 1,1,0);
        // gateway drops edges while in service
        V(0,0,1,8'h08,0,0, 0,1,1);       V(0,0,0,0,0,8'h01, 0,0,0);
        V(0,0,0,0,0,0, 0,0,0);           V(0,0,0,0,0,8'h01, 0,0,0);
        V(0,0,0,0,0,0, 0,0,0);           V(0,1,0,8'h08,1,0, 0,0,0);
        V(0,0,0,0,0,0, 0,0,0);           V(0,0,0,0,0,8'h01, 0,0,0);
        V(0,0,0,0,0,0, 1,1,0);
        // bogus completes ignored; state stays claimed; reset clears everything
        V(0,0,1,8'h08,0,0, 0,1,1);       V(0,1,0,8'h08,9,0, 0,0,0);
        V(0,1,0,8'h08,2,0, 0,0,0);       V(0,0,0,0,0,8'h20, 0,0,0);
        V(0,0,0,0,0,0, 0,6,0);           V(1,0,0,0,0,0, 0,0,0);
        V(0,0,1,8'h08,0,0, 0,0,0);       V(0,0,1,8'h00,0,0, 0,0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wd, tbl[i].src);
            check($sformatf("vec%0d int_req", i), 32'(int_req_o), 32'(tbl[i].req));
            check($sformatf("vec%0d int_id", i), 32'(int_id_o), 32'(tbl[i].id));
            check($sformatf("vec%0d rdata", i), rdata_o, tbl[i].rd);
        end

        // Randomized traffic against the model.
        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            int r;
            bit rr, w, rd;
            logic [7:0] a, s;
            logic [31:0] wd;
            r = $urandom_range(0, 99);
            rr = 0; w = 0; rd = 0; a = 0; wd = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : src_i;
            if (r < 2) rr = 1;
            else if (r < 14) begin
                w = 1;
                case ($urandom_range(0, 3))
                    0: a = 8'h00;
                    1: begin a = 8'h04; wd = 32'($urandom_range(0, 3)); end
                    2: a = 8'h0C;
                    default: a = 8'(16 + 4 * $urandom_range(0, 7));
                endcase
            end else if (r < 24) begin
                rd = 1;
                case ($urandom_range(0, 4))
                    0: a = 8'h00;
                    1: a = 8'h04;
                    2: a = 8'h30;
                    3: a = 8'h11;
                    default: a = 8'(16 + 4 * $urandom_range(0, 7));
                endcase
            end else if (r < 36) begin
                rd = 1; a = 8'h08;
            end else if (r < 48) begin
                w = 1; a = 8'h08;
                wd = ($urandom_range(0, 1) == 0) ? 32'(m_claimed) : 32'($urandom_range(0, 10));
            end
            drive(rr, w, rd, a, wd, s);
            check($sformatf("rnd%0d int_req", c), 32'(int_req_o), 32'(m_req));
            check($sformatf("rnd%0d int_id", c), 32'(int_id_o), 32'(m_id));
            check($sformatf("rnd%0d rdata", c), rdata_o, 32'(m_rd));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
